motor_link_watchdog: RTL

- Sits between the GBT receive frame and the motor application's control path.
- Passes motor control and memory data through only while the serial interlock word is valid and frames keep arriving.
- On a timeout or a bad interlock, forces the motor word to all-ones, which makes every motor assert StepDeactivate.
- Re-arming needs a run of consecutive good frames; this stops the motors reacting to a flapping link.

---
 rtl/motor_link_watchdog.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/motor_link_watchdog.sv
// Gates GBT rx motor/memory words on interlock validity and frame liveness; 1-cycle reg-to-reg latency, no backpressure.
// Define MOTOR_LINK_WATCHDOG_LATCH_EN to hold drops in LATCHED until clear_i instead of re-arming automatically.
package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module motor_link_watchdog #(
  parameter logic [31:0] g_interlock      = 32'h0,
  parameter int unsigned g_timeout_frames = 4000,
  parameter int unsigned g_arm_frames     = 8
) (
  input  ckrs_pkg::ckrs_t ClkRs_ix,
  input  logic            rx_clken_i,
  input  logic [31:0]     interlock_ib32,
  input  logic [63:0]     motor_data_ib64,
  input  logic [15:0]     mem_data_ib16,
  input  logic            clear_i,
  output logic [63:0]     motor_data_ob64,
  output logic [15:0]     mem_data_ob16,
  output logic            mem_valid_o,
  output logic            link_active_o,
  output logic [1:0]      state_ob2,
  output logic [15:0]     drop_count_ob16
);

  typedef enum logic [1:0] {
    ST_SAFE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_LATCHED = 2'd3
  } state_t;

`ifdef MOTOR_LINK_WATCHDOG_LATCH_EN
  localparam state_t EXIT_STATE = ST_LATCHED;
`else
  localparam state_t EXIT_STATE = ST_SAFE;
  logic unused_clear;
  assign unused_clear = clear_i;
`endif

  logic clk;
  logic rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  state_t      state_q,       state_d;
  logic [7:0]  arm_cnt_q,     arm_cnt_d;
  logic [15:0] gap_cnt_q,     gap_cnt_d;
  logic [63:0] motor_q,       motor_d;
  logic [15:0] mem_q,         mem_d;
  logic        mem_vld_q,     mem_vld_d;
  logic        link_active_q, link_active_d;
  logic [15:0] drop_cnt_q,    drop_cnt_d;

  logic        good_frame;
  logic        bad_frame;
  logic [8:0]  arm_nxt;
  logic [16:0] gap_nxt;
  logic        gap_expired;

  assign good_frame  = rx_clken_i && (interlock_ib32 == g_interlock);
  assign bad_frame   = rx_clken_i && (interlock_ib32 != g_interlock);
  assign arm_nxt     = {1'b0, arm_cnt_q} + 9'd1;
  assign gap_nxt     = {1'b0, gap_cnt_q} + 17'd1;
  // Fires only on a strobe-less cycle, so a frame landing on the limit wins.
  assign gap_expired = gap_nxt >= 17'(g_timeout_frames);

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    motor_d    = motor_q;
    mem_d      = mem_q;
    mem_vld_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      ST_SAFE: begin
        motor_d   = '1;
        gap_cnt_d = '0;
        arm_cnt_d = '0;
        if (good_frame) begin
          if (g_arm_frames == 1) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d   = ST_ARMING;
            arm_cnt_d = 8'd1;
          end
        end
      end

      ST_ARMING: begin
        motor_d = '1;
        if (good_frame) begin
          gap_cnt_d = '0;
          if (arm_nxt == 9'(g_arm_frames)) begin
            state_d   = ST_ACTIVE;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_nxt[7:0];
          end
        end else if (bad_frame || gap_expired) begin
          state_d   = ST_SAFE;
          arm_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_nxt[15:0];
        end
      end

      ST_ACTIVE: begin
        arm_cnt_d = '0;
        if (good_frame) begin
          motor_d   = motor_data_ib64;
          mem_d     = mem_data_ib16;
          mem_vld_d = 1'b1;
          gap_cnt_d = '0;
        end else if (bad_frame || gap_expired) begin
          // Motors go safe in the same edge that leaves ACTIVE.
          motor_d   = '1;
          state_d   = EXIT_STATE;
          gap_cnt_d = '0;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          gap_cnt_d = gap_nxt[15:0];
        end
      end

      ST_LATCHED: begin
        motor_d   = '1;
        gap_cnt_d = '0;
        arm_cnt_d = '0;
`ifdef MOTOR_LINK_WATCHDOG_LATCH_EN
        if (clear_i) begin
          state_d = ST_SAFE;
        end
`else
        state_d = ST_SAFE;
`endif
      end

      default: begin
        state_d = ST_SAFE;
        motor_d = '1;
      end
    endcase

    link_active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SAFE;
      arm_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      motor_q       <= '1;
      mem_q         <= '0;
      mem_vld_q     <= 1'b0;
      link_active_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      motor_q       <= motor_d;
      mem_q         <= mem_d;
      mem_vld_q     <= mem_vld_d;
      link_active_q <= link_active_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign motor_data_ob64 = motor_q;
  assign mem_data_ob16   = mem_q;
  assign mem_valid_o     = mem_vld_q;
  assign link_active_o   = link_active_q;
  assign state_ob2       = state_q;
  assign drop_count_ob16 = drop_cnt_q;

endmodule
